// File: rtl/segdisp_pkg.sv
// -----------------------------------------------------------------------------
// segdisp_pkg
// Shared constants for the seven-segment display controller:
//   - register offsets (even halfword offsets; odd offsets alias down)
//   - CTRL reset value (all digits enabled, no decimal points)
//   - hex-to-segment table, active-low {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
package segdisp_pkg;

    localparam logic [2:0] ADDR_DLO  = 3'b000;
    localparam logic [2:0] ADDR_DHI  = 3'b010;
    localparam logic [2:0] ADDR_CTRL = 3'b100;

    localparam logic [15:0] CTRL_RESET = 16'h00FF;

    // Packed so that HEX_SEG[n] is the pattern for nibble n (entry 0 is the
    // rightmost element of the concatenation).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/segdisp_hex_decode.sv
// -----------------------------------------------------------------------------
// seg_hex_decode
// Combinational hex digit to seven-segment decoder.
// Ports:
//   nibble  in  4  hex digit value
//   seg     out 7  active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg_hex_decode
    import segdisp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/segdisp.sv
// -----------------------------------------------------------------------------
// segdisp
// Memory-mapped 8-digit seven-segment display controller.
// Holds the 32-bit display value (DLO/DHI) and the CTRL masks, and scans the
// eight active-low digits with a prescaled slot counter. The first BLANK
// cycles of every slot turn all digits off to avoid ghosting.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   segcs     in   chip select from IO decoder
//   segwrite  in   write strobe
//   segread   in   read strobe
//   segaddr   in   [2:0] halfword offset (bit 0 ignored)
//   segwdata  in   [15:0] write data
//   segrdata  out  [15:0] combinational read data, 0 when not selected
//   seg_out   out  [7:0] {dp,g,f,e,d,c,b,a}, active-low, registered
//   seg_en    out  [7:0] digit enables, active-low, registered
// -----------------------------------------------------------------------------
module segdisp
    import segdisp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int BLANK    = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        segcs,
    input  logic        segwrite,
    input  logic        segread,
    input  logic [2:0]  segaddr,
    input  logic [15:0] segwdata,
    output logic [15:0] segrdata,
    output logic [7:0]  seg_out,
    output logic [7:0]  seg_en
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [15:0]   dlo_q, dlo_d;
    logic [15:0]   dhi_q, dhi_d;
    logic [15:0]   ctrl_q, ctrl_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    seg_out_q, seg_out_d;
    logic [7:0]    seg_en_q, seg_en_d;

    logic [2:0]    addr_even;
    logic          unused_addr_lsb;
    logic [31:0]   digits;
    logic [3:0]    nibble;
    logic [6:0]    seg7;
    logic [7:0]    en_mask;
    logic [7:0]    dp_mask;
    logic          blank_now;
    logic          show;

    // Odd offsets alias to the even offset below them.
    assign addr_even       = {segaddr[2:1], 1'b0};
    assign unused_addr_lsb = segaddr[0];

    // Register file writes; the reserved offset falls through to default.
    always_comb begin
        dlo_d  = dlo_q;
        dhi_d  = dhi_q;
        ctrl_d = ctrl_q;
        if (segcs && segwrite) begin
            case (addr_even)
                ADDR_DLO:  dlo_d  = segwdata;
                ADDR_DHI:  dhi_d  = segwdata;
                ADDR_CTRL: ctrl_d = segwdata;
                default:   ;
            endcase
        end
    end

    // Read path is combinational and sees the pre-write register value.
    always_comb begin
        segrdata = 16'h0000;
        if (segcs && segread) begin
            case (addr_even)
                ADDR_DLO:  segrdata = dlo_q;
                ADDR_DHI:  segrdata = dhi_q;
                ADDR_CTRL: segrdata = ctrl_q;
                default:   segrdata = 16'h0000;
            endcase
        end
    end

    // Prescaler and digit index; idx wraps naturally at 3 bits.
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 3'd1;
        end
    end

    // With no blanking the comparison would be constant, so skip it.
    if (BLANK == 0) begin : g_no_blank
        assign blank_now = 1'b0;
    end else begin : g_blank
        assign blank_now = (presc_q < PW'(BLANK));
    end

    assign digits  = {dhi_q, dlo_q};
    assign nibble  = digits[{idx_q, 2'b00} +: 4];
    assign en_mask = ctrl_q[7:0];
    assign dp_mask = ctrl_q[15:8];

    seg_hex_decode u_hex_decode (
        .nibble (nibble),
        .seg    (seg7)
    );

    // Output selection for the current slot, registered below.
    always_comb begin
        show      = !blank_now && en_mask[idx_q];
        seg_en_d  = 8'hFF;
        seg_out_d = 8'hFF;
        if (show) begin
            seg_en_d  = ~(8'h01 << idx_q);
            seg_out_d = {~dp_mask[idx_q], seg7};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dlo_q     <= 16'h0000;
            dhi_q     <= 16'h0000;
            ctrl_q    <= CTRL_RESET;
            presc_q   <= '0;
            idx_q     <= 3'd0;
            seg_out_q <= 8'hFF;
            seg_en_q  <= 8'hFF;
        end else begin
            dlo_q     <= dlo_d;
            dhi_q     <= dhi_d;
            ctrl_q    <= ctrl_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            seg_out_q <= seg_out_d;
            seg_en_q  <= seg_en_d;
        end
    end

    assign seg_out = seg_out_q;
    assign seg_en  = seg_en_q;

endmodule
